// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: op encoding,
// FSM states and the RISC-V defined divide special-case results.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide-by-zero or signed-overflow result; op[1] selects remainder vs quotient.
  function automatic logic [XLEN_DEF-1:0] special_result(
    input logic [2:0]          op,
    input logic [XLEN_DEF-1:0] a,
    input logic                b_zero
  );
    if (b_zero) return op[1] ? a : '1;
    return op[1] ? '0 : {1'b1, {(XLEN_DEF-1){1'b0}}};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement: passes val through, or negates it when neg is set.
module muldiv_sign_fix #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (32 shift-add / restoring-divide steps).
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at once.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_t            state;
  logic [2:0]        op_q;
  logic              sa_q, sb_q, div_zero_q;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              sa_in, sb_in, b_zero;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] acc_next, prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed, final_res;

  assign sa_in  = a[XLEN-1] & (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                               op == OP_DIV || op == OP_REM);
  assign sb_in  = b[XLEN-1] & (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign b_zero = op[2] && (b == '0);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.neg(sa_in), .val(a), .res(abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.neg(sb_in), .val(b), .res(abs_b));

  // acc holds {partial product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; both start as {0, |a|}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_b : '0)};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_trial = div_shift - {1'b0, mag_b};
    acc_next  = '0;
    if (!op_q[2])
      acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (!div_trial[XLEN])
      acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_prod_fix (.neg(sa_q ^ sb_q), .val(acc_next), .res(prod_fixed));
  muldiv_sign_fix #(.W(XLEN)) u_quo_fix (.neg(sa_q ^ sb_q), .val(acc_next[XLEN-1:0]),
                                         .res(quo_fixed));
  muldiv_sign_fix #(.W(XLEN)) u_rem_fix (.neg(sa_q), .val(acc_next[2*XLEN-1:XLEN]),
                                         .res(rem_fixed));

  // Signed overflow and REM-by-zero fall out of the magnitude datapath;
  // only the divide-by-zero quotient needs forcing.
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:           final_res = prod_fixed[XLEN-1:0];
      OP_DIV, OP_DIVU:  final_res = div_zero_q ? '1 : quo_fixed;
      OP_REM, OP_REMU:  final_res = rem_fixed;
      default:          final_res = prod_fixed[2*XLEN-1:XLEN];
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic special_in;
  assign special_in = b_zero ||
                      ((op == OP_DIV || op == OP_REM) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      div_zero_q <= 1'b0;
      mag_b      <= '0;
      acc        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            div_zero_q <= b_zero;
            mag_b      <= abs_b;
            acc        <= {{XLEN{1'b0}}, abs_a};
            cnt        <= '0;
            busy       <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (special_in) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_result(op, a, b_zero);
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= final_res;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
